pair_frame_receiver: RTL and testbench
======================================

# pair_frame_receiver

Downstream consumer of the TIA-568B pair outputs of the link front end: samples the 1-2/3-6 differential pair on the 100 MHz clock, recovers bit timing by oversampling, hunts for a sync byte, and assembles LSB-first bytes into frames. Bytes leave through a 4-entry FIFO with a valid/ready handshake and an end-of-frame flag, for the packet layer.

## Interface
- OVERSAMPLE, 4: clock cycles per line bit, even, 4..16.
- SYNC_BYTE, 8'hD5: byte that opens a frame; it is not delivered.
- IDLE_BITS, 2: consecutive idle bit times that close a frame, 1..7.

Ports:
- Clock100MhzP  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high.
- PairP  input  1  asynchronous line, driven from TIA_568B12.
- PairN  input  1  asynchronous line, driven from TIA_568B36.
- OutReady  input  1  consumer accepts OutByte this cycle.
- OutByte  output  8  FIFO head byte.
- OutValid  output  1  FIFO non-empty.
- OutLast  output  1  head byte is the last byte of its frame.
- FrameError  output  1  one-cycle pulse on a malformed or overflowed frame.
- LinkUp  output  1  high while in RECEIVE.

## Operation
- Both lines pass through 2-flop synchronizers. Symbol decode on the synchronized pair: P=1,N=0 -> bit 1; P=0,N=1 -> bit 0; P==N -> idle.
- Phase counter, 0..OVERSAMPLE-1: cleared to 0 on any change of the decoded symbol, otherwise increments and wraps. A symbol is sampled in each cycle where phase == OVERSAMPLE/2.
- State machine:
  - HUNT: each sampled data bit shifts into an 8-bit register, LSB-first (new bit enters bit 7, shift right). Idle samples clear the register. When the register equals SYNC_BYTE, go to RECEIVE, clear the bit count, and empty the staging register.
  - RECEIVE: sampled data bits are assembled LSB-first, and the bit count goes 0..7.
    - At 8 bits: if the staging register is full, its byte is pushed with last=0. The new byte then enters staging.
    - Each idle sample increments the idle count. Any data sample clears the idle count.
    - When the idle count reaches IDLE_BITS, the frame ends. If bit count == 0 and staging is full, push staging with last=1. If bit count != 0, pulse FrameError, discard the partial byte, and push staging with last=1 when present. Go to HUNT.
    - A frame that ends with staging empty (sync followed only by idle) pushes nothing and raises no error.
  - Overflow: a push while the FIFO is full (and not popping in the same cycle) drops the byte, pulses FrameError, and forces HUNT. Bytes already in the FIFO are kept.
- FIFO: 4 entries of {last, byte}. A pop happens when OutValid && OutReady. A push and pop in the same cycle while full are both accepted.
- Reset clears the synchronizers, phase, counters, shift and staging registers, and the FIFO, and enters HUNT. Reset asserted mid-frame drops all data.

## Timing
- Reset values: OutByte=0, OutValid=0, OutLast=0, FrameError=0, LinkUp=0.
- Synchronizer latency is 2 cycles. A sample is taken OVERSAMPLE/2 cycles after the synchronized edge.
- A push occurs in the cycle after the completing sample. OutValid rises the cycle after the push.
- A byte is visible only after the following byte completes or the frame ends (1-byte staging delay).
- LinkUp rises the cycle after the SYNC_BYTE match and falls the cycle after frame end or overflow.
- FrameError is exactly 1 cycle wide. It is the registered output of the error event.
- OutByte/OutLast hold steady while OutValid && !OutReady.

## Test plan
- Frame with OVERSAMPLE=4: send D5, then 11 22 33, then 2 idle bits, with OutReady=1. Required: bytes 11, 22, 33 delivered, OutLast=1 only on 33, FrameError never asserted, LinkUp high from sync until end.
- Partial byte: D5, AA, then 3 data bits, then idle. Required: AA delivered with OutLast=1, FrameError pulses once, return to HUNT.
- Backpressure and overflow: OutReady=0, send D5 plus 6 bytes 01..06. Required: 01..04 fill the FIFO, the push of 05 overflows, FrameError pulses, then HUNT. Releasing OutReady drains 01..04 with OutLast=0 on all four.
- Jitter: bit periods alternate 3 and 5 cycles, carrying D5 then 5A. Required: 5A received correctly with OutLast=1.
- False sync: send D4, D6, then idle. Required: LinkUp stays 0 and OutValid stays 0. Then D5 followed by 7E. Required: 7E delivered.
- Reset mid-frame: assert Reset for 1 cycle after 2 bytes. Required: all outputs return to their reset values the next cycle, the FIFO is empty, and the next D5 frame is received normally.

Source files
------------

// File: rtl/pair_frame_receiver.sv
// pair_frame_receiver: oversampled differential pair receiver.
// Hunts for a sync byte, assembles LSB-first bytes, queues them with an end-of-frame flag.
module pair_frame_receiver #(
  parameter int         OVERSAMPLE = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hD5,
  parameter int         IDLE_BITS  = 2
) (
  input  logic       Clock100MhzP,
  input  logic       Reset,
  input  logic       PairP,
  input  logic       PairN,
  input  logic       OutReady,
  output logic [7:0] OutByte,
  output logic       OutValid,
  output logic       OutLast,
  output logic       FrameError,
  output logic       LinkUp
);

  localparam int PW = $clog2(OVERSAMPLE);

  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2);
  localparam logic [2:0]    IDLE_LAST = 3'(IDLE_BITS - 1);

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] RECEIVE = 1'b1;

  // bit 1: carries data, bit 0: data value
  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_ZERO = 2'b10;
  localparam logic [1:0] SYM_ONE  = 2'b11;

  logic [1:0] p_sync;
  logic [1:0] n_sync;
  logic       p_line;
  logic       n_line;

  logic [1:0]    sym;
  logic [1:0]    sym_q;
  logic [PW-1:0] phase;
  logic          sample;
  logic          s_data;
  logic          s_bit;

  logic [0:0] state;
  logic [7:0] shift;
  logic [7:0] nb;
  logic [2:0] bit_cnt;
  logic [2:0] idle_cnt;
  logic [7:0] stage_byte;
  logic       stage_full;

  logic       push_v;
  logic [7:0] push_byte;
  logic       push_last;

  logic       frame_end;
  logic       err_evt;
  logic       overflow;

  logic [8:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       full;
  logic       pop;
  logic       push_ok;

  always_ff @(posedge Clock100MhzP) begin
    if (Reset) begin
      p_sync <= 2'b00;
      n_sync <= 2'b00;
    end else begin
      p_sync <= {p_sync[0], PairP};
      n_sync <= {n_sync[0], PairN};
    end
  end

  assign p_line = p_sync[1];
  assign n_line = n_sync[1];

  always_comb begin
    sym = SYM_IDLE;
    unique case (1'b1)
      (p_line && !n_line): sym = SYM_ONE;
      (!p_line && n_line): sym = SYM_ZERO;
      default:             sym = SYM_IDLE;
    endcase
  end

  // phase counts how long sym_q has been stable
  always_ff @(posedge Clock100MhzP) begin
    if (Reset) begin
      sym_q <= SYM_IDLE;
      phase <= '0;
    end else begin
      sym_q <= sym;
      if (sym != sym_q) begin
        phase <= '0;
      end else if (phase == PH_LAST) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  assign sample = (phase == PH_MID);
  assign s_data = sym_q[1];
  assign s_bit  = sym_q[0];
  assign nb     = {s_bit, shift[7:1]};

  assign frame_end = sample && (state == RECEIVE)
                  && !s_data && (idle_cnt == IDLE_LAST);
  assign err_evt   = frame_end && (bit_cnt != 3'd0);

  assign full     = (count == 3'd4);
  assign pop      = OutValid && OutReady;
  assign push_ok  = push_v && (!full || pop);
  assign overflow = push_v && full && !pop;

  always_ff @(posedge Clock100MhzP) begin
    if (Reset) begin
      state      <= HUNT;
      shift      <= 8'd0;
      bit_cnt    <= 3'd0;
      idle_cnt   <= 3'd0;
      stage_byte <= 8'd0;
      stage_full <= 1'b0;
      push_v     <= 1'b0;
      push_byte  <= 8'd0;
      push_last  <= 1'b0;
    end else begin
      push_v <= 1'b0;
      if (overflow) begin
        state      <= HUNT;
        shift      <= 8'd0;
        bit_cnt    <= 3'd0;
        idle_cnt   <= 3'd0;
        stage_full <= 1'b0;
      end else if (sample) begin
        unique case (state)
          HUNT: begin
            if (!s_data) begin
              shift <= 8'd0;
            end else if (nb == SYNC_BYTE) begin
              state      <= RECEIVE;
              shift      <= 8'd0;
              bit_cnt    <= 3'd0;
              idle_cnt   <= 3'd0;
              stage_full <= 1'b0;
            end else begin
              shift <= nb;
            end
          end
          RECEIVE: begin
            if (s_data) begin
              idle_cnt <= 3'd0;
              shift    <= nb;
              bit_cnt  <= bit_cnt + 3'd1;
              // previous byte leaves staging only once the next one is whole
              if (bit_cnt == 3'd7) begin
                push_v     <= stage_full;
                push_byte  <= stage_byte;
                push_last  <= 1'b0;
                stage_byte <= nb;
                stage_full <= 1'b1;
              end
            end else if (frame_end) begin
              push_v     <= stage_full;
              push_byte  <= stage_byte;
              push_last  <= 1'b1;
              state      <= HUNT;
              shift      <= 8'd0;
              bit_cnt    <= 3'd0;
              idle_cnt   <= 3'd0;
              stage_full <= 1'b0;
            end else begin
              idle_cnt <= idle_cnt + 3'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge Clock100MhzP) begin
    if (Reset) begin
      FrameError <= 1'b0;
    end else begin
      FrameError <= err_evt || overflow;
    end
  end

  assign LinkUp = (state == RECEIVE);

  always_ff @(posedge Clock100MhzP) begin
    if (push_ok) begin
      mem[wr_ptr] <= {push_last, push_byte};
    end
  end

  always_ff @(posedge Clock100MhzP) begin
    if (Reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign OutValid = (count != 3'd0);
  assign OutByte  = OutValid ? mem[rd_ptr][7:0] : 8'd0;
  assign OutLast  = OutValid ? mem[rd_ptr][8] : 1'b0;

endmodule

// File: tb/tb_pair_frame_receiver.sv
// tb_pair_frame_receiver: scoreboard bench for pair_frame_receiver.
// Symbols are fed to a frame-level model; a monitor checks every delivered byte.
module tb_pair_frame_receiver;

  localparam int         OS   = 4;
  localparam int         IB   = 2;
  localparam logic [7:0] SYNC = 8'hD5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pp  = 1'b0;
  logic       pn  = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] ob;
  logic       ov;
  logic       ol;
  logic       fe;
  logic       lu;

  always #5 clk = ~clk;

  pair_frame_receiver #(
    .OVERSAMPLE(OS),
    .SYNC_BYTE (SYNC),
    .IDLE_BITS (IB)
  ) dut (
    .Clock100MhzP(clk),
    .Reset       (rst),
    .PairP       (pp),
    .PairN       (pn),
    .OutReady    (rdy),
    .OutByte     (ob),
    .OutValid    (ov),
    .OutLast     (ol),
    .FrameError  (fe),
    .LinkUp      (lu)
  );

  int checks = 0;
  int fails  = 0;

  logic [8:0] exp_q [$];
  int exp_err = 0;
  int obs_err = 0;

  bit         m_recv;
  bit         m_have;
  bit         m_stalled;
  int         m_win;
  int         m_idle;
  int         m_occ;
  logic [7:0] m_stage;
  int         m_bits [$];

  bit rand_rdy = 0;
  bit jit_on   = 0;
  bit jit      = 0;
  bit idle_lvl = 0;
  bit saw_link = 0;
  bit saw_valid = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    m_recv = 0;
    m_have = 0;
    m_win  = 0;
    m_idle = 0;
    m_occ  = 0;
    m_bits.delete();
    exp_q.delete();
  endfunction

  function automatic void model_abort();
    m_recv = 0;
    m_have = 0;
    m_win  = 0;
    m_idle = 0;
    m_bits.delete();
  endfunction

  function automatic void model_push(logic [7:0] b, bit last);
    if (m_stalled && m_occ == 4) begin
      exp_err++;
      model_abort();
    end else begin
      exp_q.push_back({last, b});
      m_occ++;
    end
  endfunction

  // s: 0/1 data bit, 2 idle
  function automatic void model_sym(int s);
    int v;
    if (!m_recv) begin
      if (s == 2) begin
        m_win = 0;
      end else begin
        m_win = (m_win >> 1) | (s << 7);
        if (m_win == SYNC) begin
          model_abort();
          m_recv = 1;
        end
      end
    end else if (s != 2) begin
      m_idle = 0;
      m_bits.push_back(s);
      if (m_bits.size() == 8) begin
        v = 0;
        foreach (m_bits[i]) v |= m_bits[i] << i;
        m_bits.delete();
        if (m_have) model_push(m_stage, 1'b0);
        if (m_recv) begin
          m_stage = v[7:0];
          m_have  = 1;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == IB) begin
        if (m_bits.size() != 0) exp_err++;
        if (m_have) model_push(m_stage, 1'b1);
        model_abort();
      end
    end
  endfunction

  task automatic hold(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send_sym(int s);
    int per;
    per = OS;
    if (jit_on) begin
      per = jit ? 5 : 3;
      jit = !jit;
    end
    model_sym(s);
    if (s == 2) begin
      pp = idle_lvl;
      pn = idle_lvl;
    end else begin
      pp = s[0];
      pn = !s[0];
    end
    hold(per);
  endtask

  task automatic send_byte(logic [7:0] b);
    for (int i = 0; i < 8; i++) send_sym(int'(b[i]));
  endtask

  task automatic send_idle(int n);
    repeat (n) send_sym(2);
  endtask

  task automatic settle(string name);
    check({name, "_errors"}, obs_err, exp_err);
    check({name, "_link"}, lu, m_recv);
  endtask

  task automatic wait_drain(string name);
    int k;
    rand_rdy = 0;
    rdy = 1'b1;
    k = 0;
    while ((exp_q.size() != 0 || ov) && k < 200) begin
      hold(1);
      k++;
    end
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_valid"}, ov, 1'b0);
  endtask

  task automatic check_reset_outputs(string name);
    check({name, "_byte"}, ob, 8'd0);
    check({name, "_valid"}, ov, 1'b0);
    check({name, "_last"}, ol, 1'b0);
    check({name, "_ferr"}, fe, 1'b0);
    check({name, "_link"}, lu, 1'b0);
  endtask

  // monitor: pops the scoreboard on every accepted byte
  initial begin
    logic [8:0] prev;
    bit prev_stall;
    bit prev_fe;
    prev = '0;
    prev_stall = 0;
    prev_fe = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        prev_fe = 0;
      end else begin
        if (prev_stall) check("hold_steady", {ov, ol, ob}, {1'b1, prev});
        if (ov && rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_byte actual=%0h required=none",
                     {ol, ob});
          end else begin
            check("out_byte", {ol, ob}, exp_q.pop_front());
          end
        end
        if (fe) begin
          obs_err++;
          check("ferr_width", prev_fe, 1'b0);
        end
        prev_fe = fe;
        prev_stall = ov && !rdy;
        prev = {ol, ob};
        if (lu) saw_link = 1;
        if (ov) saw_valid = 1;
      end
    end
  end

  initial begin
    int nb;
    int k;
    m_stalled = 0;
    model_reset();
    rst = 1'b1;
    hold(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    hold(2);
    send_idle(4);

    rdy = 1'b1;
    send_byte(SYNC);
    send_byte(8'h11);
    check("link_mid", lu, 1'b1);
    send_byte(8'h22);
    send_byte(8'h33);
    send_idle(4);
    settle("basic");

    send_byte(SYNC);
    send_byte(8'hAA);
    send_sym(1);
    send_sym(0);
    send_sym(1);
    send_idle(4);
    settle("partial");

    wait_drain("pre_stall");
    rdy = 1'b0;
    m_stalled = 1;
    m_occ = 0;
    send_byte(SYNC);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    send_idle(4);
    settle("overflow");
    check("overflow_full", ov, 1'b1);
    m_stalled = 0;
    wait_drain("overflow_drain");

    jit_on = 1;
    jit = 0;
    send_byte(SYNC);
    send_byte(8'h5A);
    send_idle(4);
    jit_on = 0;
    settle("jitter");
    wait_drain("jitter_drain");

    saw_link = 0;
    saw_valid = 0;
    send_byte(8'hD4);
    send_byte(8'hD6);
    send_idle(4);
    check("false_sync_link", saw_link, 1'b0);
    check("false_sync_valid", saw_valid, 1'b0);
    send_byte(SYNC);
    send_byte(8'h7E);
    send_idle(4);
    settle("true_sync");
    wait_drain("true_sync_drain");

    rdy = 1'b0;
    send_byte(SYNC);
    send_byte(8'h31);
    send_byte(8'h32);
    pp = 1'b0;
    pn = 1'b0;
    k = 0;
    while (!ov && k < 40) begin
      hold(1);
      k++;
    end
    check("pre_reset_valid", ov, 1'b1);
    rst = 1'b1;
    model_reset();
    hold(1);
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    rdy = 1'b1;
    send_idle(4);
    send_byte(SYNC);
    send_byte(8'h44);
    send_byte(8'h55);
    send_idle(4);
    settle("post_reset");
    wait_drain("post_reset_drain");

    rand_rdy = 1;
    for (int f = 0; f < 30; f++) begin
      idle_lvl = $urandom_range(0, 1);
      repeat ($urandom_range(0, 10)) send_sym($urandom_range(0, 1));
      send_byte(SYNC);
      nb = $urandom_range(0, 4);
      for (int b = 0; b < nb; b++) begin
        send_byte(8'($urandom));
        if ($urandom_range(0, 3) == 0) send_idle(1);
      end
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 7)) send_sym($urandom_range(0, 1));
      end
      send_idle(4);
      settle("random");
    end
    idle_lvl = 0;
    wait_drain("final_drain");
    check("final_errors", obs_err, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
